// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared channel state type and counter sizing helper for the key conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one pushbutton: two-flop synchroniser, debounce FSM and auto-repeat counter.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] REP_MAX   = RW'(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic          RAW_IDLE  = ACTIVE_LOW_IN;

  key_state_e      r_state;
  logic [1:0]      r_sync;
  logic [DW-1:0]   r_db_cnt;
  logic [RW-1:0]   r_rep_cnt;
  logic            r_rep_phase;
  logic            r_level;
  logic            r_press;
  logic            r_release;

  logic            w_pressed;
  logic [DW-1:0]   w_db_next;
  logic            w_db_done;
  logic [RW-1:0]   w_rep_next;
  logic [RW-1:0]   w_rep_target;
  logic            w_rep_done;

  // r_db_cnt is 0 whenever IDLE/HELD, so the same done test covers the first stable edge
  assign w_pressed    = r_sync[1] ^ RAW_IDLE;
  assign w_db_next    = (r_db_cnt == DB_MAX) ? r_db_cnt : r_db_cnt + 1'b1;
  assign w_db_done    = (w_db_next >= DB_MAX);
  assign w_rep_next   = (r_rep_cnt == REP_MAX) ? r_rep_cnt : r_rep_cnt + 1'b1;
  assign w_rep_target = r_rep_phase ? REP_RATE : REP_DELAY;
  assign w_rep_done   = (w_rep_next >= w_rep_target);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_sync      <= {2{RAW_IDLE}};
      r_db_cnt    <= '0;
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_raw};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b0;
          if (w_pressed) begin
            if (w_db_done) begin
              r_state  <= ST_HELD;
              r_level  <= 1'b1;
              r_press  <= 1'b1;
              r_db_cnt <= '0;
            end else begin
              r_state  <= ST_PRESS_WAIT;
              r_db_cnt <= w_db_next;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state  <= ST_IDLE;
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_state     <= ST_HELD;
            r_level     <= 1'b1;
            r_press     <= 1'b1;
            r_db_cnt    <= '0;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
          end else begin
            r_db_cnt <= w_db_next;
          end
        end
        ST_HELD: begin
          if (!w_pressed) begin
            if (w_db_done) begin
              r_state   <= ST_IDLE;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_db_cnt  <= '0;
            end else begin
              r_state  <= ST_RELEASE_WAIT;
              r_db_cnt <= w_db_next;
            end
          end else if (!i_repeat_en) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
          end else if (w_rep_done) begin
            r_press     <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep_cnt <= w_rep_next;
          end
        end
        ST_RELEASE_WAIT: begin
          // repeat counter intentionally untouched here so it resumes on bounce back to HELD
          if (w_pressed) begin
            r_state  <= ST_HELD;
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_state     <= ST_IDLE;
            r_level     <= 1'b0;
            r_release   <= 1'b1;
            r_db_cnt    <= '0;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
          end else begin
            r_db_cnt <= w_db_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - NUM_KEYS independent debounced pushbutton channels with auto-repeat.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_raw,
  input  logic [NUM_KEYS-1:0] i_repeat_en,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_press,
  output logic [NUM_KEYS-1:0] o_key_release
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
    ) u_channel (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_key_raw  (i_key_raw[g]),
      .i_repeat_en(i_repeat_en[g]),
      .o_level    (o_key_level[g]),
      .o_press    (o_key_press[g]),
      .o_release  (o_key_release[g])
    );
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 2, number of independent pushbutton channels (Run, Continue, ...); legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable synchronised cycles required to accept a level change; minimum 1.
REQ-003 Parameter REPEAT_DELAY, default 25000000, cycles from the accepted press to the first auto-repeat pulse; minimum 1.
REQ-004 Parameter REPEAT_RATE, default 5000000, cycles between subsequent auto-repeat pulses; minimum 1.
REQ-005 Parameter ACTIVE_LOW_IN, default 1, 1 = raw key reads 0 when pressed (board KEY style), 0 = reads 1 when pressed.
REQ-006 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-008 Key_raw  input  NUM_KEYS  unsynchronised pushbutton levels, polarity per ACTIVE_LOW_IN.
REQ-009 Repeat_en  input  NUM_KEYS  per-channel auto-repeat enable, synchronous to Clk.
REQ-010 Key_level  output  NUM_KEYS  debounced pressed state, always active-high.
REQ-011 Key_press  output  NUM_KEYS  one-cycle pulse per accepted press and per auto-repeat event.
REQ-012 Key_release  output  NUM_KEYS  one-cycle pulse per accepted release.

Function
REQ-013 Each channel SHALL pass Key_raw through a two-flop synchroniser, then normalise to active-high per ACTIVE_LOW_IN.
REQ-014 Each channel SHALL run FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE -> PRESS_WAIT when synchronised value = pressed; PRESS_WAIT -> IDLE immediately if it returns to released (bounce), debounce counter cleared.
REQ-016 PRESS_WAIT -> HELD when the counter reaches DEBOUNCE_CYCLES; on that edge Key_level rises and Key_press pulses.
REQ-017 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges, counting the first edge that samples the new stable raw value.
REQ-018 HELD -> RELEASE_WAIT on synchronised released; RELEASE_WAIT -> HELD on pressed again (counter cleared); RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES stable, with Key_level falling and Key_release pulsing on that edge (same DEBOUNCE_CYCLES+2 latency).
REQ-019 Repeat counter SHALL clear on the accepted-press edge and count only in HELD; with Repeat_en=1 a Key_press pulse issues REPEAT_DELAY cycles after the accepted press, then every REPEAT_RATE cycles.
REQ-020 Repeat counter SHALL freeze (not clear) in RELEASE_WAIT and resume on return to HELD; no repeat pulse in RELEASE_WAIT.
REQ-021 Repeat_en falling SHALL suppress pulses from that cycle; rising during HELD restarts the REPEAT_DELAY interval.
REQ-022 Key_press and Key_release SHALL never assert together on one channel; a pending repeat coinciding with release acceptance is dropped.
REQ-023 Counters SHALL be sized $clog2(max+1) and saturate, never wrapping.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels all reported in the same cycle.

Reset
REQ-025 Reset=0: synchronisers cleared to released level, FSMs IDLE, counters 0, Key_level/Key_press/Key_release = 0, asynchronously.
REQ-026 Reset mid-debounce or mid-repeat SHALL discard progress; a key held through reset release is re-debounced and reported as a fresh press after DEBOUNCE_CYCLES+2 edges.

Structure
REQ-027 Package key_pkg SHALL hold the channel state enum and a counter-width helper function.
REQ-028 One sub-module key_channel (synchroniser, FSM, counters) SHALL be instantiated NUM_KEYS times via generate.

Verification (NUM_KEYS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW_IN=1)
REQ-029 Key_raw[0] 1->0 held 40 cycles, Repeat_en=0 -> Key_press[0] single pulse on edge 6, Key_level[0]=1; after release Key_release[0] on edge 6.
REQ-030 Key_raw[0] bounces 0/1 every 2 cycles for 20 cycles, then stays 1 -> no pulses, Key_level[0]=0 throughout.
REQ-031 Repeat_en[1]=1, key 1 held 30 cycles past acceptance -> Key_press[1] at +0, +10, +13, +16, ... +28; none after release begins.
REQ-032 Both keys pressed same cycle -> Key_press=2'b11 on edge 6 together.
REQ-033 Reset=0 at edge 3 of PRESS_WAIT, key held -> outputs 0 at once; after Reset=1 press reported exactly 6 edges later.
REQ-034 ACTIVE_LOW_IN=0 instance, Key_raw 0->1 -> Key_level rises on edge 6, identical pulse timing.
